// File: rtl/mmio_timer.sv
// Purpose: memory-mapped countdown timer (CTRL/PRESET/COUNT) with a level interrupt output.
// Latency: reads are combinational from addr; irq rises PRESET+3 edges after an EN write (IM set).
// Backpressure: none; the responder accepts every access in the cycle it is presented.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        pending;

    logic        en;
    logic        auto_reload;
    logic        im;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] preset_merged;
    logic        pend_set;
    logic        pend_clr;
    logic        en_clr;
    logic        unused_addr_bits;

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign im          = ctrl[3];

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = hit & (|byteen);
    assign wr_ctrl   = wr & (addr[3:2] == 2'd0);
    assign wr_preset = wr & (addr[3:2] == 2'd1);

    // Word offset only; byte offset within the word is not decoded.
    assign unused_addr_bits = ^addr[1:0];

    assign irq = pending & im;

    // Read mux: selected register when the window is hit, zero otherwise.
    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rdata = {28'h0, ctrl};
                2'd1:    rdata = preset;
                2'd2:    rdata = count;
                default: rdata = 32'h0;
            endcase
        end
    end

    // Byte-lane merge of write data into the current PRESET value.
    always_comb begin
        preset_merged = preset;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                preset_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Next-state logic, evaluated on pre-edge register values.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        en_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count == 32'h0) begin
                    state_nxt = INT;
                    pend_set  = 1'b1;
                end else begin
                    count_nxt = count - 32'd1;
                end
            end
            INT: begin
                if (auto_reload) begin
                    state_nxt = LOAD;
                    pend_clr  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    en_clr    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 32'h0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // CTRL: a CPU write beats the one-shot EN clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'h0;
        end else if (wr_ctrl && byteen[0]) begin
            ctrl <= wdata[3:0];
        end else if (en_clr) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET: lane-merged CPU writes; sampled by the FSM only in LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= PRESET_RST;
        end else if (wr_preset) begin
            preset <= preset_merged;
        end
    end

    // Pending: a set from the FSM wins over any clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (pend_set) begin
            pending <= 1'b1;
        end else if (wr_ctrl || wr_preset || pend_clr) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Purpose: scoreboard bench for mmio_timer with directed, hand-computed vectors.
// Latency: each check cycle samples at the falling edge; async checks sample mid-cycle.
// Backpressure: not applicable; the stimulus owns every cycle.
module tb_mmio_timer;

    localparam logic [31:0] B = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    typedef struct {
        int          kind;   // 0 = rdata, 1 = irq, 2 = hit
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic chk_vld;
    logic kick;
    int   n_chk;
    int   n_fail;

    mmio_timer #(.BASE_ADDR(B), .PRESET_RST(32'h0)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation each time a check is presented.
    always @(negedge clk or posedge kick) begin
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_chk  = n_chk + 1;
                n_fail = n_fail + 1;
                $display("FAIL sb_empty: observation with no expected value queued");
            end else begin
                exp_t        e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.kind)
                    0:       act = rdata;
                    1:       act = {31'h0, irq};
                    default: act = {31'h0, hit};
                endcase
                n_chk = n_chk + 1;
                if (act !== e.val) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a check for the falling-edge sample; returns mid-cycle.
    task automatic chk_half(input int k, input logic [31:0] a, input logic [31:0] v, input string nm);
        addr   = a;
        byteen = 4'h0;
        sb.push_back('{kind: k, val: v, name: nm});
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    // One full cycle: observe current state, then let one rising edge pass.
    task automatic chk(input int k, input logic [31:0] a, input logic [31:0] v, input string nm);
        chk_half(k, a, v, nm);
        @(posedge clk);
        #1;
    endtask

    // Immediate sample with no clock edge involved.
    task automatic chk_async(input int k, input logic [31:0] a, input logic [31:0] v, input string nm);
        addr = a;
        #1;
        sb.push_back('{kind: k, val: v, name: nm});
        chk_vld = 1'b1;
        kick    = 1'b1;
        #1;
        kick    = 1'b0;
        chk_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;
        byteen  = 4'h0;
        chk_vld = 1'b0;
        kick    = 1'b0;
        n_chk   = 0;
        n_fail  = 0;
        @(posedge clk);
        #1;

        // T1: reset values
        chk(1, B, 32'h0, "t1_irq_in_reset");
        reset = 1'b1;
        chk(0, B + 32'h0, 32'h0, "t1_ctrl_rst");
        chk(0, B + 32'h4, 32'h0, "t1_preset_rst");
        chk(0, B + 32'h8, 32'h0, "t1_count_rst");
        chk(1, B, 32'h0, "t1_irq");
        chk(2, 32'h0, 32'h0, "t1_hit_addr0");
        chk(2, B + 32'hC, 32'h1, "t1_hit_base");

        // T2: byte-lane writes, read-only and reserved words, misses
        wr(B + 32'h4, 32'hAABB_CCDD, 4'b0011);
        chk(0, B + 32'h4, 32'h0000_CCDD, "t2_preset_lo");
        wr(B + 32'h4, 32'h1122_3344, 4'b1100);
        chk(0, B + 32'h4, 32'h1122_CCDD, "t2_preset_hi");
        wr(B + 32'h8, 32'hFFFF_FFFF, 4'hF);
        chk(0, B + 32'h8, 32'h0, "t2_count_ro");
        wr(B + 32'hC, 32'hFFFF_FFFF, 4'hF);
        chk(0, B + 32'hC, 32'h0, "t2_reserved");
        wr(32'h0000_3F04, 32'h0, 4'hF);
        chk(0, B + 32'h4, 32'h1122_CCDD, "t2_miss_write");
        chk(0, B + 32'h14, 32'h0, "t2_miss_read");
        wr(B, 32'hFFFF_FFF8, 4'hF);
        chk(0, B, 32'h8, "t2_ctrl_upper");
        wr(B, 32'h0, 4'hF);

        // T3: one-shot, PRESET=3
        wr(B + 32'h4, 32'd3, 4'hF);
        wr(B, 32'h9, 4'hF);
        chk(1, B, 32'h0, "t3_irq_t0");
        chk(1, B, 32'h0, "t3_irq_t1");
        chk(0, B + 32'h8, 32'd3, "t3_count3");
        chk(0, B + 32'h8, 32'd2, "t3_count2");
        chk(0, B + 32'h8, 32'd1, "t3_count1");
        chk(0, B + 32'h8, 32'd0, "t3_count0");
        chk(1, B, 32'h1, "t3_irq_t6");
        chk(0, B, 32'h8, "t3_ctrl_en_clr");
        chk(1, B, 32'h1, "t3_irq_held");
        wr(B, 32'h8, 4'b0001);
        chk(1, B, 32'h0, "t3_irq_cleared");
        wr(B, 32'h0, 4'hF);

        // T4: auto-reload, PRESET=2, period 5
        wr(B + 32'h4, 32'd2, 4'hF);
        wr(B, 32'hB, 4'hF);
        chk(1, B, 32'h0, "t4_irq_t0");
        chk(1, B, 32'h0, "t4_irq_t1");
        chk(0, B + 32'h8, 32'd2, "t4_count2");
        chk(0, B + 32'h8, 32'd1, "t4_count1");
        chk(0, B + 32'h8, 32'd0, "t4_count0");
        chk(1, B, 32'h1, "t4_irq_t5");
        chk(1, B, 32'h0, "t4_irq_t6");
        chk(0, B + 32'h8, 32'd2, "t4_reload");
        chk(1, B, 32'h0, "t4_irq_t8");
        chk(1, B, 32'h0, "t4_irq_t9");
        chk(1, B, 32'h1, "t4_irq_t10");
        chk(1, B, 32'h0, "t4_irq_t11");
        wr(B, 32'h0, 4'hF);
        idle(2);

        // T5: disable mid-count, then restart from PRESET
        wr(B + 32'h4, 32'd7, 4'hF);
        wr(B, 32'h1, 4'hF);
        idle(2);
        chk(0, B + 32'h8, 32'd7, "t5_count7");
        chk(0, B + 32'h8, 32'd6, "t5_count6");
        wr(B, 32'h0, 4'hF);
        chk(0, B + 32'h8, 32'd4, "t5_frozen_a");
        chk(0, B + 32'h8, 32'd4, "t5_frozen_b");
        chk(1, B, 32'h0, "t5_no_irq");
        wr(B, 32'h1, 4'hF);
        idle(1);
        chk(0, B + 32'h8, 32'd4, "t5_load_pending");
        chk(0, B + 32'h8, 32'd7, "t5_restart");
        wr(B, 32'h0, 4'hF);
        idle(2);

        // T6a: asynchronous reset while in INT
        wr(B + 32'h4, 32'd1, 4'hF);
        wr(B, 32'h9, 4'hF);
        idle(4);
        chk_half(1, B, 32'h1, "t6_irq_in_int");
        reset = 1'b0;
        chk_async(1, B, 32'h0, "t6_irq_async_fall");
        @(posedge clk);
        #1;
        chk(0, B, 32'h0, "t6_ctrl_rst");
        chk(0, B + 32'h4, 32'h0, "t6_preset_rst");
        chk(0, B + 32'h8, 32'h0, "t6_count_rst");
        reset = 1'b1;

        // T6b: CPU CTRL write on the INT edge keeps EN
        wr(B + 32'h4, 32'd1, 4'hF);
        wr(B, 32'h9, 4'hF);
        idle(4);
        wr(B, 32'h9, 4'hF);
        chk(1, B, 32'h0, "t6_pending_cleared");
        chk(0, B, 32'h9, "t6_ctrl_cpu_wins");
        chk(0, B + 32'h8, 32'd1, "t6_reloaded");
        chk(0, B + 32'h8, 32'd0, "t6_count0");
        chk(1, B, 32'h1, "t6_irq_again");
        wr(B, 32'h0, 4'hF);
        idle(2);

        if (sb.size() != 0) begin
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL sb_leftover: %0d expectations never observed, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
